// File: rtl/ieu_pkg.sv
// Shared ALU opcode constants, EX-slot bundle and funct7 selection helper for the ID/EX issue stage.
// The slot bundle is sized by XLEN_DEF/REG_ADDR_W_DEF; set XLEN_DEF to 64 for an RV64 build.
package ieu_pkg;

   localparam int XLEN_DEF       = 32;
   localparam int REG_ADDR_W_DEF = 5;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASEOP = 7'b0000000;
   localparam logic [6:0] F7_ALTOP  = 7'b0100000;

   // SRLI/SRAI is the only immediate op whose funct7 field carries meaning.
   localparam logic [2:0] F3_SRA = F3_SR;

   typedef struct packed {
      logic [XLEN_DEF-1:0]       pc;
      logic [REG_ADDR_W_DEF-1:0] rd;
      logic                      wb_en;
      logic                      is_load;
      logic [2:0]                funct3;
      logic [6:0]                funct7;
      logic [XLEN_DEF-1:0]       operand_1;
      logic [XLEN_DEF-1:0]       operand_2;
      logic [XLEN_DEF-1:0]       rs2_data;
   } ex_slot_t;

   function automatic logic [6:0] sel_funct7(input logic use_imm, input logic [2:0] funct3,
                                             input logic [6:0] funct7);
      return (use_imm && funct3 != F3_SRA) ? F7_BASEOP : funct7;
   endfunction

endpackage

// File: rtl/ieu_fwd_mux.sv
// Forwarding priority mux for one source register: EX > MEM > WB > register file, x0 reads as 0.
// Purely combinational, no latency and no flow control.
module ieu_fwd_mux #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] addr_i,
   input  logic [XLEN-1:0]       rf_data_i,
   input  logic                  ex_fwd_vld_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic [XLEN-1:0]       ex_result_i,
   input  logic                  mem_fwd_vld_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_i,
   input  logic [XLEN-1:0]       mem_result_i,
   input  logic                  wb_fwd_vld_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic [XLEN-1:0]       wb_data_i,
   output logic [XLEN-1:0]       data_o
);

   always_comb begin
      data_o = rf_data_i;
      if (addr_i == '0)
         data_o = '0;
      else if (ex_fwd_vld_i && ex_rd_i == addr_i)
         data_o = ex_result_i;
      else if (mem_fwd_vld_i && mem_rd_i == addr_i)
         data_o = mem_result_i;
      else if (wb_fwd_vld_i && wb_rd_i == addr_i)
         data_o = wb_data_i;
   end

endmodule

// File: rtl/ieu_issue.sv
// ID/EX issue stage: resolves forwarded operands and registers them for the ALU, one-cycle latency.
// Stalls decode while EX is held by ex_ready or on a load-use hazard; flush empties the EX slot.
module ieu_issue
   import ieu_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  dec_valid,
   output logic                  dec_ready,
   input  logic [XLEN-1:0]       dec_pc,
   input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
   input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
   input  logic [REG_ADDR_W-1:0] dec_rd_addr,
   input  logic                  dec_rs1_en,
   input  logic                  dec_rs2_en,
   input  logic [XLEN-1:0]       dec_rs1_data,
   input  logic [XLEN-1:0]       dec_rs2_data,
   input  logic [XLEN-1:0]       dec_imm,
   input  logic                  dec_use_imm,
   input  logic                  dec_use_pc,
   input  logic [2:0]            dec_funct3,
   input  logic [6:0]            dec_funct7,
   input  logic                  dec_wb_en,
   input  logic                  dec_is_load,
   input  logic [XLEN-1:0]       ex_result,
   input  logic                  mem_valid,
   input  logic                  mem_wb_en,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_result,
   input  logic                  wb_valid,
   input  logic                  wb_wb_en,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  ex_ready,
   output logic                  ex_valid,
   output logic [2:0]            alu_funct3,
   output logic [6:0]            alu_funct7,
   output logic [XLEN-1:0]       alu_operand_1,
   output logic [XLEN-1:0]       alu_operand_2,
   output logic [XLEN-1:0]       ex_rs2_data,
   output logic [XLEN-1:0]       ex_pc,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_wb_en,
   output logic                  ex_is_load
);

   ex_slot_t        ex_q, ex_d;
   logic            ex_valid_q;
   logic            hazard, capture, ex_fwd_vld;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2;

   // A load in EX cannot forward; its consumer must wait one bubble for the MEM path.
   assign hazard = ex_valid_q && ex_q.is_load && ex_q.wb_en && ex_q.rd != '0 &&
                   ((dec_rs1_en && dec_rs1_addr == ex_q.rd) ||
                    (dec_rs2_en && dec_rs2_addr == ex_q.rd));

   assign dec_ready  = (!ex_valid_q || ex_ready) && !hazard;
   assign capture    = dec_valid && dec_ready && !flush;
   assign ex_fwd_vld = ex_valid_q && ex_q.wb_en && !ex_q.is_load;

   ieu_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
      .addr_i(dec_rs1_addr), .rf_data_i(dec_rs1_data),
      .ex_fwd_vld_i(ex_fwd_vld), .ex_rd_i(ex_q.rd), .ex_result_i(ex_result),
      .mem_fwd_vld_i(mem_valid && mem_wb_en), .mem_rd_i(mem_rd), .mem_result_i(mem_result),
      .wb_fwd_vld_i(wb_valid && wb_wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .data_o(fwd_rs1)
   );

   ieu_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
      .addr_i(dec_rs2_addr), .rf_data_i(dec_rs2_data),
      .ex_fwd_vld_i(ex_fwd_vld), .ex_rd_i(ex_q.rd), .ex_result_i(ex_result),
      .mem_fwd_vld_i(mem_valid && mem_wb_en), .mem_rd_i(mem_rd), .mem_result_i(mem_result),
      .wb_fwd_vld_i(wb_valid && wb_wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .data_o(fwd_rs2)
   );

   always_comb begin
      ex_d           = '0;
      ex_d.pc        = dec_pc;
      ex_d.rd        = dec_rd_addr;
      ex_d.wb_en     = dec_wb_en;
      ex_d.is_load   = dec_is_load;
      ex_d.funct3    = dec_funct3;
      ex_d.funct7    = sel_funct7(dec_use_imm, dec_funct3, dec_funct7);
      ex_d.operand_1 = dec_use_pc  ? dec_pc  : fwd_rs1;
      ex_d.operand_2 = dec_use_imm ? dec_imm : fwd_rs2;
      ex_d.rs2_data  = fwd_rs2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else if (flush) begin
         ex_valid_q <= 1'b0;
      end else if (capture) begin
         ex_valid_q <= 1'b1;
         ex_q       <= ex_d;
      end else if (ex_ready) begin
         ex_valid_q <= 1'b0;
      end
   end

   assign ex_valid      = ex_valid_q;
   assign alu_funct3    = ex_q.funct3;
   assign alu_funct7    = ex_q.funct7;
   assign alu_operand_1 = ex_q.operand_1;
   assign alu_operand_2 = ex_q.operand_2;
   assign ex_rs2_data   = ex_q.rs2_data;
   assign ex_pc         = ex_q.pc;
   assign ex_rd         = ex_q.rd;
   assign ex_wb_en      = ex_q.wb_en;
   assign ex_is_load    = ex_q.is_load;

endmodule
